// File: rtl/uart_rx_frame_decoder_if.sv
// Byte stream in from the UART receiver, framed words and frame status out.
// master = decoder side, slave = receiver/consumer side.
interface uart_rx_frame_decoder_if #(
    parameter int W = 16
);
    logic         rx_data_ready;
    logic [7:0]   rx_data;
    logic         rx_endofpacket;
    logic         word_valid;
    logic [W-1:0] word_data;
    logic [7:0]   word_index;
    logic         frame_start;
    logic         frame_ok;
    logic         frame_err;
    logic [1:0]   err_code;
    logic         busy;

    modport master (
        input  rx_data_ready, rx_data, rx_endofpacket,
        output word_valid, word_data, word_index,
        output frame_start, frame_ok, frame_err, err_code, busy
    );

    modport slave (
        output rx_data_ready, rx_data, rx_endofpacket,
        input  word_valid, word_data, word_index,
        input  frame_start, frame_ok, frame_err, err_code, busy
    );
endinterface

// File: rtl/uart_rx_frame_decoder.sv
// Extracts SYNC/LEN/payload/CSUM frames from a UART byte stream into words.
// Every output is registered: strobes appear one cycle after the causing byte; no backpressure.
module uart_rx_frame_decoder #(
    parameter int         WORD_BYTES = 2,
    parameter int         MAX_WORDS  = 64,
    parameter logic [7:0] SYNC_BYTE  = 8'hAA
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_rx_frame_decoder_if.master bus
);
    localparam int         W         = 8 * WORD_BYTES;
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);
    localparam logic [7:0] MAX_LEN   = 8'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CSUM    = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     len_q, len_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     word_cnt_q, word_cnt_d;
    logic [7:0]     sum_q, sum_d;
    logic [W-1:0]   asm_q, asm_d;
    logic           word_valid_q, word_valid_d;
    logic [W-1:0]   word_data_q, word_data_d;
    logic [7:0]     word_index_q, word_index_d;
    logic           frame_start_q, frame_start_d;
    logic           frame_ok_q, frame_ok_d;
    logic           frame_err_q, frame_err_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [W-1:0]   asm_next;
    logic [7:0]     sum_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            word_cnt_q    <= '0;
            sum_q         <= '0;
            asm_q         <= '0;
            word_valid_q  <= 1'b0;
            word_data_q   <= '0;
            word_index_q  <= '0;
            frame_start_q <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            byte_cnt_q    <= byte_cnt_d;
            word_cnt_q    <= word_cnt_d;
            sum_q         <= sum_d;
            asm_q         <= asm_d;
            word_valid_q  <= word_valid_d;
            word_data_q   <= word_data_d;
            word_index_q  <= word_index_d;
            frame_start_q <= frame_start_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        sum_d         = sum_q;
        asm_d         = asm_q;
        word_valid_d  = 1'b0;
        word_data_d   = word_data_q;
        word_index_d  = word_index_q;
        frame_start_d = 1'b0;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        sum_next      = sum_q + bus.rx_data;
        // Current byte merged into its little-endian lane of the word in progress.
        asm_next      = asm_q;
        asm_next[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;

        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_data_ready && bus.rx_data == SYNC_BYTE) begin
                    state_d       = S_LEN;
                    frame_start_d = 1'b1;
                    sum_d         = '0;
                    byte_cnt_d    = '0;
                    word_cnt_d    = '0;
                    asm_d         = '0;
                end
            end
            S_LEN: begin
                if (bus.rx_data_ready) begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN) begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                    end else begin
                        state_d = S_PAYLOAD;
                        len_d   = bus.rx_data;
                        sum_d   = bus.rx_data;
                    end
                end else if (bus.rx_endofpacket) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd3;
                end
            end
            S_PAYLOAD: begin
                if (bus.rx_data_ready) begin
                    sum_d = sum_next;
                    asm_d = asm_next;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d   = '0;
                        word_valid_d = 1'b1;
                        word_data_d  = asm_next;
                        word_index_d = word_cnt_q;
                        word_cnt_d   = word_cnt_q + 8'd1;
                        if (word_cnt_q == len_q - 8'd1) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (bus.rx_endofpacket) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd3;
                end
            end
            S_CSUM: begin
                state_d = (bus.rx_data_ready || bus.rx_endofpacket) ? S_IDLE : S_CSUM;
                if (bus.rx_data_ready) begin
                    if (sum_next == 8'd0) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                end else if (bus.rx_endofpacket) begin
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd3;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.word_valid  = word_valid_q;
    assign bus.word_data   = word_data_q;
    assign bus.word_index  = word_index_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_code    = err_code_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Bench for uart_rx_frame_decoder: byte table plus scoreboard of expected strobes.
module tb_uart_rx_frame_decoder;
    typedef enum int {EV_NONE = 0, EV_START = 1, EV_WORD = 2, EV_OK = 3, EV_ERR = 4} ev_e;

    typedef struct {
        logic       dv;
        logic       eop;
        logic [7:0] dat;
        ev_e        kind;
        logic [15:0] word;
        logic [7:0] idx;
        logic [1:0] code;
        logic       busy;
    } vec_t;

    typedef struct {
        ev_e         kind;
        logic [15:0] word;
        logic [7:0]  idx;
        logic [1:0]  code;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t sb[$];

    uart_rx_frame_decoder_if #(.W(16)) bus ();

    uart_rx_frame_decoder #(
        .WORD_BYTES(2),
        .MAX_WORDS (64),
        .SYNC_BYTE (8'hAA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic dv, input logic eop, input logic [7:0] dat,
                                input ev_e kind, input logic [15:0] word, input logic [7:0] idx,
                                input logic [1:0] code, input logic busy);
        vec_t v;
        v.dv = dv; v.eop = eop; v.dat = dat; v.kind = kind;
        v.word = word; v.idx = idx; v.code = code; v.busy = busy;
        return v;
    endfunction

    function automatic void b(input logic [7:0] dat, input ev_e kind, input logic [15:0] word,
                              input logic [7:0] idx, input logic [1:0] code, input logic busy);
        vecs.push_back(mk(1'b1, 1'b0, dat, kind, word, idx, code, busy));
    endfunction

    task automatic push_exp(input vec_t v);
        exp_t e;
        if (v.kind != EV_NONE) begin
            e.kind = v.kind; e.word = v.word; e.idx = v.idx; e.code = v.code;
            sb.push_back(e);
        end
    endtask

    // One byte followed by an idle cycle, then busy and err_code are checked.
    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.rx_data_ready  = v.dv;
        bus.rx_endofpacket = v.eop;
        bus.rx_data        = v.dat;
        push_exp(v);
        @(negedge clk);
        bus.rx_data_ready  = 1'b0;
        bus.rx_endofpacket = 1'b0;
        bus.rx_data        = 8'h00;
        @(negedge clk);
        check("busy", 32'(bus.busy), 32'(v.busy));
        check("err_code_hold", 32'(bus.err_code), 32'(v.code));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word_data"},  32'(bus.word_data), 32'h0);
        check({tag, "_word_index"}, 32'(bus.word_index), 32'h0);
        check({tag, "_err_code"},   32'(bus.err_code), 32'h0);
        check({tag, "_busy"},       32'(bus.busy), 32'h0);
        check({tag, "_strobes"},
              32'({bus.word_valid, bus.frame_start, bus.frame_ok, bus.frame_err}), 32'h0);
    endtask

    // Scoreboard: every strobe seen is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (bus.word_valid || bus.frame_start || bus.frame_ok || bus.frame_err)) begin
            ev_e  act;
            exp_t e;
            check("one_strobe", 32'(int'(bus.word_valid) + int'(bus.frame_start) +
                                    int'(bus.frame_ok) + int'(bus.frame_err)), 32'd1);
            act = bus.frame_start ? EV_START : bus.word_valid ? EV_WORD :
                  bus.frame_ok ? EV_OK : EV_ERR;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'(act), 32'(EV_NONE));
            end else begin
                e = sb.pop_front();
                check("strobe_kind", 32'(act), 32'(e.kind));
                check("err_code", 32'(bus.err_code), 32'(e.code));
                if (e.kind == EV_WORD) begin
                    check("word_data", 32'(bus.word_data), 32'(e.word));
                    check("word_index", 32'(bus.word_index), 32'(e.idx));
                end
            end
        end
    end

    initial begin
        bus.rx_data_ready  = 1'b0;
        bus.rx_endofpacket = 1'b0;
        bus.rx_data        = 8'h00;

        // Good single-word frame
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h01, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h34, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h12, EV_WORD,  16'h1234, 8'd0, 2'd0, 1'b1);
        b(8'hB9, EV_OK,    16'h0, 8'd0, 2'd0, 1'b0);
        // Two words
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h02, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h01, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h00, EV_WORD,  16'h0001, 8'd0, 2'd0, 1'b1);
        b(8'h02, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h00, EV_WORD,  16'h0002, 8'd1, 2'd0, 1'b1);
        b(8'hFB, EV_OK,    16'h0, 8'd0, 2'd0, 1'b0);
        // Bad checksum, then recovery
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h01, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h34, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1);
        b(8'h12, EV_WORD,  16'h1234, 8'd0, 2'd0, 1'b1);
        b(8'hB8, EV_ERR,   16'h0, 8'd0, 2'd2, 1'b0);
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd2, 1'b1);
        b(8'h01, EV_NONE,  16'h0, 8'd0, 2'd2, 1'b1);
        b(8'h34, EV_NONE,  16'h0, 8'd0, 2'd2, 1'b1);
        b(8'h12, EV_WORD,  16'h1234, 8'd0, 2'd2, 1'b1);
        b(8'hB9, EV_OK,    16'h0, 8'd0, 2'd2, 1'b0);
        // Noise, LEN=0, LEN=65, LEN=64 accepted then timeout
        b(8'h55, EV_NONE,  16'h0, 8'd0, 2'd2, 1'b0);
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd2, 1'b1);
        b(8'h00, EV_ERR,   16'h0, 8'd0, 2'd1, 1'b0);
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd1, 1'b1);
        b(8'h41, EV_ERR,   16'h0, 8'd0, 2'd1, 1'b0);
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd1, 1'b1);
        b(8'h40, EV_NONE,  16'h0, 8'd0, 2'd1, 1'b1);
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, EV_ERR, 16'h0, 8'd0, 2'd3, 1'b0));
        // Timeout mid-word, then eop in idle is ignored
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd3, 1'b1);
        b(8'h02, EV_NONE,  16'h0, 8'd0, 2'd3, 1'b1);
        b(8'h01, EV_NONE,  16'h0, 8'd0, 2'd3, 1'b1);
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, EV_ERR,  16'h0, 8'd0, 2'd3, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, EV_NONE, 16'h0, 8'd0, 2'd3, 1'b0));
        // SYNC value inside the payload is plain data
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd3, 1'b1);
        b(8'h01, EV_NONE,  16'h0, 8'd0, 2'd3, 1'b1);
        b(8'hAA, EV_NONE,  16'h0, 8'd0, 2'd3, 1'b1);
        b(8'h00, EV_WORD,  16'h00AA, 8'd0, 2'd3, 1'b1);
        b(8'h55, EV_OK,    16'h0, 8'd0, 2'd3, 1'b0);
        // Byte and eop together: byte wins
        b(8'hAA, EV_START, 16'h0, 8'd0, 2'd3, 1'b1);
        vecs.push_back(mk(1'b1, 1'b1, 8'h01, EV_NONE, 16'h0, 8'd0, 2'd3, 1'b1));
        b(8'h34, EV_NONE,  16'h0, 8'd0, 2'd3, 1'b1);
        b(8'h12, EV_WORD,  16'h1234, 8'd0, 2'd3, 1'b1);
        b(8'hB9, EV_OK,    16'h0, 8'd0, 2'd3, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Back-to-back frames, one byte per cycle
        begin
            logic [7:0] bytes [10];
            ev_e        kinds [10];
            bytes = '{8'hAA, 8'h01, 8'h34, 8'h12, 8'hB9, 8'hAA, 8'h01, 8'h34, 8'h12, 8'hB9};
            kinds = '{EV_START, EV_NONE, EV_NONE, EV_WORD, EV_OK,
                      EV_START, EV_NONE, EV_NONE, EV_WORD, EV_OK};
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                bus.rx_data_ready = 1'b1;
                bus.rx_data       = bytes[k];
                push_exp(mk(1'b1, 1'b0, bytes[k], kinds[k], 16'h1234, 8'd0, 2'd3, 1'b0));
            end
            @(negedge clk);
            bus.rx_data_ready = 1'b0;
            bus.rx_data       = 8'h00;
            @(negedge clk);
            check("b2b_busy", 32'(bus.busy), 32'h0);
        end

        // Reset mid-frame discards everything, then a good frame passes
        apply(mk(1'b1, 1'b0, 8'hAA, EV_START, 16'h0, 8'd0, 2'd3, 1'b1));
        apply(mk(1'b1, 1'b0, 8'h01, EV_NONE,  16'h0, 8'd0, 2'd3, 1'b1));
        apply(mk(1'b1, 1'b0, 8'h34, EV_NONE,  16'h0, 8'd0, 2'd3, 1'b1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        check_all_zero("midreset_hold");
        rst = 1'b0;
        apply(mk(1'b1, 1'b0, 8'h12, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b0));
        apply(mk(1'b1, 1'b0, 8'hAA, EV_START, 16'h0, 8'd0, 2'd0, 1'b1));
        apply(mk(1'b1, 1'b0, 8'h01, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1));
        apply(mk(1'b1, 1'b0, 8'h34, EV_NONE,  16'h0, 8'd0, 2'd0, 1'b1));
        apply(mk(1'b1, 1'b0, 8'h12, EV_WORD,  16'h1234, 8'd0, 2'd0, 1'b1));
        apply(mk(1'b1, 1'b0, 8'hB9, EV_OK,    16'h0, 8'd0, 2'd0, 1'b0));

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_decoder.md
Name: uart_rx_frame_decoder

Overview:
- Sits directly downstream of the UART receiver.
- Consumes its byte stream (data-ready strobe, data byte, end-of-packet strobe) and extracts framed multi-byte words for the neural-network weight/input loaders.
- Frame format: SYNC byte, LEN byte (word count), LEN*WORD_BYTES payload bytes (little-endian per word), CSUM byte.
- Words are emitted as they complete. The frame is declared good or bad only at its end, so the consumer must hold words until frame_ok and drop them on frame_err.

Parameters:
- WORD_BYTES, 2: bytes per output word; output width W = 8*WORD_BYTES; legal 1..4.
- MAX_WORDS, 64: largest accepted LEN; legal 1..255.
- SYNC_BYTE, 8'hAA: frame start marker.

Ports:
- clk  in  1  system clock, same clock as the receiver.
- rst  in  1  asynchronous active-high reset.
- rx_data_ready  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_data  in  8  received byte.
- rx_endofpacket  in  1  one-cycle strobe; line has gone idle.
- word_valid  out  1  one-cycle strobe; word_data and word_index are valid.
- word_data  out  W  assembled word; byte 0 received goes to bits [7:0].
- word_index  out  8  0-based index of the word within its frame.
- frame_start  out  1  one-cycle strobe; a SYNC byte was accepted.
- frame_ok  out  1  one-cycle strobe; checksum passed.
- frame_err  out  1  one-cycle strobe; frame aborted.
- err_code  out  2  cause of the last frame_err: 1 = bad LEN, 2 = checksum, 3 = timeout. Held until the next frame_err or reset.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - All outputs are 0: word_data=0, word_index=0, err_code=0, all strobes 0.
  - Internal byte counter, word counter, checksum accumulator and assembly register are cleared.
  - Reset mid-frame discards the partial frame and issues no strobe.
- All outputs are registered. Each strobe goes high the cycle after the rx_data_ready (or rx_endofpacket) that caused it, for exactly one cycle.
- Bytes are acted on only while rx_data_ready=1.
- State IDLE:
  - byte == SYNC_BYTE: go to LEN, pulse frame_start, clear sum/counters.
  - Any other byte is ignored silently.
- State LEN:
  - byte == 0 or byte > MAX_WORDS: pulse frame_err, err_code=1, go to IDLE.
  - Otherwise latch len, sum = byte, go to PAYLOAD.
- State PAYLOAD:
  - Each byte: sum += byte (mod 256). The byte is shifted into the assembly register at position byte_cnt; byte_cnt counts 0..WORD_BYTES-1.
  - On the last byte of a word: word_valid=1 and word_data = completed word; word_index = word count, which then increments; byte_cnt wraps to 0.
  - After word len-1 completes: go to CSUM.
- State CSUM:
  - (sum + byte) mod 256 == 0: pulse frame_ok.
  - Otherwise: pulse frame_err, err_code=2.
  - Go to IDLE in both cases.
- Timeout: rx_endofpacket=1 while in LEN, PAYLOAD or CSUM pulses frame_err with err_code=3 and returns to IDLE. In IDLE, rx_endofpacket is ignored.
- Simultaneous rx_data_ready and rx_endofpacket: the byte is processed and rx_endofpacket is ignored that cycle.
- A SYNC_BYTE value inside LEN, PAYLOAD or CSUM is treated as data; there is no resynchronisation mid-frame.
- Back-to-back frames: a SYNC byte arriving on the first byte after CSUM is accepted, with no gap cycles required.
- No backpressure: the consumer must accept word_valid on every strobe. Successive strobes are at least one receiver byte time apart.
- word_data and word_index hold their value between strobes.

Test Plan:
- Default params; bytes AA 01 34 12 B9 → frame_start; then word_valid with word_data=16'h1234, word_index=0; then frame_ok; err_code stays 0.
- Bytes AA 02 01 00 02 00 FB → words 16'h0001 (idx 0) and 16'h0002 (idx 1), then frame_ok.
- Same as the first scenario but CSUM=B8 → word 16'h1234 still emitted, then frame_err with err_code=2. The next frame AA 01 34 12 B9 then passes (frame_ok).
- Bytes 55 AA 00, then AA 41 → 55 ignored; frame_err err_code=1 for LEN=0 and again for LEN=0x41 (>64); busy=0 after each.
- Bytes AA 02 01, then rx_endofpacket → frame_err err_code=3, no word_valid, busy=0. Also assert rst after AA 01 34 → all outputs 0, no strobes, and a following good frame passes.
